trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter p_nchannels, default 2, number of monitored val/rdy channels (1..8).
REQ-002 Parameter p_msg_nbits, default 8, message width per channel.
REQ-003 Parameter p_depth, default 16, capture entries; power of two, >= 2.
REQ-004 Parameter p_cycle_nbits, default 16, cycle-stamp width.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mon_val  input  p_nchannels  per-channel valid; bit i is channel i.
REQ-008 mon_rdy  input  p_nchannels  per-channel ready.
REQ-009 mon_msg  input  p_nchannels*p_msg_nbits  channel i at bits [i*p_msg_nbits +: p_msg_nbits].
REQ-010 level  input  2  0 = capture off, 1 = fires only, 2/3 = fires and stalls.
REQ-011 arm  input  1  start-capture pulse.
REQ-012 trigger  input  1  trigger pulse.
REQ-013 post_count  input  16  entries to capture after trigger; sampled on accepted arm.
REQ-014 rd_val / rd_rdy  output / input  1 / 1  readout stream handshake.
REQ-015 rd_msg  output  p_cycle_nbits+2*p_nchannels+p_nchannels*p_msg_nbits  entry {cycle, val mask, rdy mask, msgs}, cycle in MSBs.
REQ-016 state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DRAIN.
REQ-017 cycles  output  p_cycle_nbits  free-running cycle counter.

Function
REQ-018 cycles SHALL increment by 1 every non-reset cycle and wrap modulo 2^p_cycle_nbits.
REQ-019 Channel i fires when mon_val[i] && mon_rdy[i]; stalls when mon_val[i] && !mon_rdy[i].
REQ-020 Qualifying cycle: level==1 and any fire, or level>=2 and any mon_val bit set; level==0 never qualifies.
REQ-021 In ARMED or POST, a qualifying cycle SHALL write one entry {cycles, mon_val, mon_rdy, mon_msg} at wr_ptr; wr_ptr increments modulo p_depth; fill saturates at p_depth (oldest overwritten).
REQ-022 IDLE -> ARMED on arm; clears wr_ptr and fill, latches post_count; arm in any other state ignored.
REQ-023 ARMED -> POST on trigger with latched post_count > 0; ARMED -> DRAIN on trigger with post_count == 0; trigger outside ARMED ignored; arm cycle itself does not sample trigger.
REQ-024 Trigger-cycle qualifying event SHALL be written; it does not decrement the post counter.
REQ-025 In POST each written entry decrements the post counter; the write taking it to 0 moves state to DRAIN next cycle.
REQ-026 In DRAIN no writes occur; rd_val = (fill > 0); rd_msg = entry at rd_ptr, combinational from storage.
REQ-027 On entering DRAIN, rd_ptr = (wr_ptr - fill) mod p_depth (oldest entry first).
REQ-028 Each rd_val && rd_rdy advances rd_ptr modulo p_depth and decrements fill; when fill reaches 0 state returns to IDLE next cycle.
REQ-029 DRAIN with fill == 0 on entry SHALL return to IDLE next cycle with rd_val never asserted.
REQ-030 rd_val SHALL be 0 in IDLE, ARMED, POST; rd_msg is don't-care when rd_val == 0.
REQ-031 A written entry SHALL be readable no earlier than the next cycle.

Reset
REQ-032 reset SHALL force state = IDLE, cycles = 0, wr_ptr = rd_ptr = fill = 0, post counter = 0, rd_val = 0.
REQ-033 reset asserted mid-capture or mid-drain SHALL discard all entries; storage contents need not be cleared.
REQ-034 reset overrides arm and trigger in the same cycle.

Verification
REQ-035 level=1, arm at cycle 2, ch0 fires msg 0x11 at cycle 5, trigger at 6, post_count=0 -> DRAIN; one entry {5, val 01, rdy 01, msg 0x..11}; IDLE after handshake.
REQ-036 p_depth=16, 20 fires at cycles 10..29 in ARMED, trigger at 30 no event -> 16 entries read, stamps 14..29 in order.
REQ-037 post_count=3, trigger with ch1 firing, then 3 further fires -> DRAIN after 3rd post entry; 4 entries total.
REQ-038 level=2, ch0 val=1 rdy=0 at cycle 8 -> entry captured with val 01, rdy 00; same stimulus at level=1 -> no entry.
REQ-039 rd_rdy held 0 for 5 DRAIN cycles then 1 -> rd_msg stable, no entry lost or duplicated.
REQ-040 reset at cycle 3 of POST -> state 0, rd_val 0; new arm/trigger with no events -> DRAIN then IDLE, rd_val never 1.

Source files
------------

// File: rtl/trace_capture.sv
// Captures val/rdy channel activity into a circular trace buffer around a trigger,
// then streams the captured entries out oldest-first.
module trace_capture #(
    parameter int p_nchannels   = 2,
    parameter int p_msg_nbits   = 8,
    parameter int p_depth       = 16,
    parameter int p_cycle_nbits = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [p_nchannels-1:0]                 mon_val,
    input  logic [p_nchannels-1:0]                 mon_rdy,
    input  logic [p_nchannels*p_msg_nbits-1:0]     mon_msg,
    input  logic [1:0]                             level,
    input  logic                                   arm,
    input  logic                                   trigger,
    input  logic [15:0]                            post_count,
    output logic                                   rd_val,
    input  logic                                   rd_rdy,
    output logic [p_cycle_nbits+2*p_nchannels+p_nchannels*p_msg_nbits-1:0] rd_msg,
    output logic [1:0]                             state,
    output logic [p_cycle_nbits-1:0]               cycles
);
    localparam int EW = p_cycle_nbits + 2*p_nchannels + p_nchannels*p_msg_nbits;
    localparam int AW = $clog2(p_depth);
    localparam logic [AW:0] FULL = (AW+1)'(p_depth);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]              fill_q, fill_d;
    logic [15:0]              post_q, post_d;
    logic [p_cycle_nbits-1:0] cycles_q;
    logic [EW-1:0]            mem_q [p_depth];

    logic          qual, wr_en;
    logic [AW-1:0] rd_ptr;

    assign qual = ((level == 2'd1) && |(mon_val & mon_rdy)) || (level[1] && |mon_val);

    // No writes happen in DRAIN, so the oldest entry always sits fill slots behind wr_ptr.
    assign rd_ptr = wr_ptr_q - fill_q[AW-1:0];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        post_d   = post_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    post_d   = post_count;
                end
            end
            S_ARMED: begin
                wr_en = qual;
                if (trigger) state_d = (post_q == 16'd0) ? S_DRAIN : S_POST;
            end
            S_POST: begin
                wr_en = qual;
                if (qual) begin
                    post_d = post_q - 16'd1;
                    if (post_q == 16'd1) state_d = S_DRAIN;
                end
            end
            default: begin
                if (fill_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_rdy) begin
                    fill_d = fill_q - (AW+1)'(1);
                    if (fill_q == (AW+1)'(1)) state_d = S_IDLE;
                end
            end
        endcase
        // Ring overwrite: once full, fill holds and the oldest slot is reused.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            post_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            post_q   <= post_d;
            cycles_q <= cycles_q + p_cycle_nbits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[wr_ptr_q] <= {cycles_q, mon_val, mon_rdy, mon_msg};
    end

    assign rd_val = (state_q == S_DRAIN) && (fill_q != '0);
    assign rd_msg = mem_q[rd_ptr];
    assign state  = state_q;
    assign cycles = cycles_q;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: a scoreboard queue collects expected entries as
// stimulus is applied and is drained against the readout stream.
module tb_trace_capture;
    localparam int NCH = 2;
    localparam int MW  = 8;
    localparam int DEPTH = 16;
    localparam int CW  = 16;
    localparam int EW  = CW + 2*NCH + NCH*MW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    mon_val = '0;
    logic [NCH-1:0]    mon_rdy = '0;
    logic [NCH*MW-1:0] mon_msg = '0;
    logic [1:0]        level = 2'd0;
    logic              arm = 1'b0;
    logic              trigger = 1'b0;
    logic [15:0]       post_count = '0;
    logic              rd_val;
    logic              rd_rdy = 1'b0;
    logic [EW-1:0]     rd_msg;
    logic [1:0]        state;
    logic [CW-1:0]     cycles;

    trace_capture #(.p_nchannels(NCH), .p_msg_nbits(MW), .p_depth(DEPTH), .p_cycle_nbits(CW)) dut (
        .clk(clk), .reset(reset), .mon_val(mon_val), .mon_rdy(mon_rdy), .mon_msg(mon_msg),
        .level(level), .arm(arm), .trigger(trigger), .post_count(post_count),
        .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_msg(rd_msg), .state(state), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] tcyc = '0;
    int            mph = 0;
    int            mpost = 0;
    logic [EW-1:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic [EW-1:0] e);
        sb.push_back(e);
        if (sb.size() > DEPTH) void'(sb.pop_front());
    endtask

    // One clock: update the reference model from the inputs, then step past the edge.
    task automatic tick();
        logic q;
        logic [EW-1:0] e;
        q = ((level == 2'd1) && |(mon_val & mon_rdy)) || ((level >= 2'd2) && |mon_val);
        e = {tcyc, mon_val, mon_rdy, mon_msg};
        if (reset) begin
            mph = 0; mpost = 0; sb.delete();
        end else begin
            case (mph)
                0: if (arm) begin mph = 1; mpost = post_count; sb.delete(); end
                1: begin
                    if (q) push_entry(e);
                    if (trigger) mph = (mpost == 0) ? 3 : 2;
                end
                2: if (q) begin
                    push_entry(e);
                    mpost--;
                    if (mpost == 0) mph = 3;
                end
                default: begin
                    if (sb.size() == 0) mph = 0;
                    else if (rd_rdy) begin
                        void'(sb.pop_front());
                        if (sb.size() == 0) mph = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        tcyc = reset ? '0 : tcyc + 1'b1;
        #1;
    endtask

    task automatic fire(input logic [NCH-1:0] v, input logic [NCH-1:0] r, input logic [NCH*MW-1:0] m);
        mon_val = v; mon_rdy = r; mon_msg = m;
        tick();
        mon_val = '0; mon_rdy = '0; mon_msg = '0;
    endtask

    task automatic do_arm(input logic [15:0] pc);
        arm = 1'b1; post_count = pc;
        tick();
        arm = 1'b0;
        chk("state_armed", state, 1);
    endtask

    task automatic drain(input int n_exp, input int stall);
        int budget = 200;
        chk("state_drain", state, 3);
        chk("n_entries", sb.size(), n_exp);
        rd_rdy = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_val", rd_val, sb.size() > 0);
            if (sb.size() > 0) chk("stall_msg", rd_msg, sb[0]);
            tick();
        end
        rd_rdy = 1'b1;
        while (mph == 3 && budget > 0) begin
            chk("rd_val", rd_val, sb.size() > 0);
            if (sb.size() > 0) chk("rd_msg", rd_msg, sb[0]);
            tick();
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 0, 1);
        rd_rdy = 1'b0;
        chk("idle_after_drain", state, 0);
        chk("rd_val_idle", rd_val, 0);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_rd_val", rd_val, 0);

        // Single fire, trigger with post_count 0
        level = 2'd1;
        tick();
        do_arm(16'd0);
        tick(); tick();
        fire(2'b01, 2'b01, 16'h0011);
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("cycles_track", cycles, tcyc);
        drain(1, 0);

        // Overflow: 20 fires, only the newest 16 survive
        do_arm(16'd0);
        for (int i = 0; i < 20; i++) fire(2'b01, 2'b01, 16'(i * 7 + 3));
        trigger = 1'b1; tick(); trigger = 1'b0;
        drain(16, 3);

        // Post-trigger capture of 3 entries, trigger cycle itself captured
        do_arm(16'd3);
        tick();
        trigger = 1'b1; mon_val = 2'b10; mon_rdy = 2'b10; mon_msg = 16'hAB00;
        tick();
        trigger = 1'b0; mon_val = '0; mon_rdy = '0; mon_msg = '0;
        chk("state_post", state, 2);
        fire(2'b01, 2'b01, 16'h0021);
        fire(2'b01, 2'b00, 16'h0022);
        fire(2'b11, 2'b11, 16'h3322);
        chk("state_post_mid", state, 2);
        fire(2'b10, 2'b10, 16'h4400);
        drain(4, 5);

        // level 2 captures stalls
        level = 2'd2;
        do_arm(16'd0);
        fire(2'b01, 2'b00, 16'h0055);
        trigger = 1'b1; tick(); trigger = 1'b0;
        drain(1, 0);

        // level 1 ignores stalls, level 0 ignores everything
        level = 2'd1;
        do_arm(16'd0);
        fire(2'b01, 2'b00, 16'h0055);
        level = 2'd0;
        fire(2'b11, 2'b11, 16'h6666);
        trigger = 1'b1; tick(); trigger = 1'b0;
        drain(0, 2);

        // Reset mid-POST overrides arm/trigger and discards entries
        level = 2'd1;
        do_arm(16'd5);
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int i = 0; i < 3; i++) fire(2'b01, 2'b01, 16'(8'h70 + i));
        chk("state_post_pre_rst", state, 2);
        reset = 1'b1; arm = 1'b1; trigger = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b0; trigger = 1'b0;
        chk("rst2_state", state, 0);
        chk("rst2_rd_val", rd_val, 0);
        chk("rst2_cycles", cycles, 0);
        tick();
        do_arm(16'd0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        drain(0, 0);
        chk("cycles_end", cycles, tcyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
